time_scheduler: RTL and testbench

Central emulation-time scheduler for the clock generators. It scans the next-event times requested by NREQ clock instances and selects the earliest one. It then broadcasts that value as `time_next`, together with per-requester `time_eq` flags. Each requester uses those flags to decide whether its clock edge fires this epoch. It sits in the system-clock domain between the clock generators and the emulator top, and gives run, halt and single-step control over emulated time.

---
 rtl/time_scheduler_pkg.sv | 14 +
 rtl/time_scheduler_if.sv | 41 ++++
 rtl/time_scheduler_min_scan.sv | 64 ++++++
 rtl/time_scheduler.sv | 144 ++++++++++++++
 tb/tb_time_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/time_scheduler_pkg.sv
// Shared time type, limits and scheduler state encoding for the emulation-time scheduler.
package time_package;

  localparam int TIME_W = 32;
  typedef logic [TIME_W-1:0] TIME_FORMAT;
  localparam TIME_FORMAT TIME_MAX = '1;

  typedef enum logic [1:0] {
    HALT,
    SCAN,
    COMMIT
  } sched_state_t;

endpackage

// File: rtl/time_scheduler_if.sv
// Request/broadcast bundle between the clock generators (master) and the scheduler (slave).
// TIME_SCHEDULER_LIMIT_EN adds the time_limit / limit_hit pair.
interface time_scheduler_if #(
  parameter int NREQ = 4
);
  import time_package::*;

  TIME_FORMAT        time_req [NREQ];
  logic [NREQ-1:0]   req_valid;
  logic              run;
  logic              step;
  TIME_FORMAT        time_next;
  logic [NREQ-1:0]   time_eq;
  logic              emu_tick;
  logic              idle;
  logic              err;
  logic [31:0]       epoch_count;
`ifdef TIME_SCHEDULER_LIMIT_EN
  TIME_FORMAT        time_limit;
  logic              limit_hit;

  modport master (
    output time_req, req_valid, run, step, time_limit,
    input  time_next, time_eq, emu_tick, idle, err, epoch_count, limit_hit
  );
  modport slave (
    input  time_req, req_valid, run, step, time_limit,
    output time_next, time_eq, emu_tick, idle, err, epoch_count, limit_hit
  );
`else
  modport master (
    output time_req, req_valid, run, step,
    input  time_next, time_eq, emu_tick, idle, err, epoch_count
  );
  modport slave (
    input  time_req, req_valid, run, step,
    output time_next, time_eq, emu_tick, idle, err, epoch_count
  );
`endif

endinterface

// File: rtl/time_scheduler_min_scan.sv
// Sequential minimum finder: visits one requester per cycle and keeps the smallest valid time.
module time_min_scan
  import time_package::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic            start,
  input  TIME_FORMAT      time_req [NREQ],
  input  logic [NREQ-1:0] req_valid,
  input  TIME_FORMAT      time_next,
  output logic            done,
  output logic            below,
  output logic            any_valid,
  output TIME_FORMAT      min_acc
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0] idx_reg;
  logic             busy_reg;
  TIME_FORMAT       min_acc_reg;
  logic             any_valid_reg;
  TIME_FORMAT       cur_req;
  logic             cur_valid;

  assign cur_req   = time_req[idx_reg];
  assign cur_valid = req_valid[idx_reg];

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      idx_reg       <= '0;
      busy_reg      <= 1'b0;
      min_acc_reg   <= TIME_MAX;
      any_valid_reg <= 1'b0;
    end else if (start) begin
      idx_reg       <= '0;
      busy_reg      <= 1'b1;
      min_acc_reg   <= TIME_MAX;
      any_valid_reg <= 1'b0;
    end else if (busy_reg) begin
      // strict less-than keeps the first of several tied requests
      if (cur_valid && (cur_req < min_acc_reg)) begin
        min_acc_reg <= cur_req;
      end
      if (cur_valid) begin
        any_valid_reg <= 1'b1;
      end
      if (idx_reg == IDX_LAST) begin
        busy_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign done      = busy_reg && (idx_reg == IDX_LAST);
  assign below     = busy_reg && cur_valid && (cur_req < time_next);
  assign any_valid = any_valid_reg;
  assign min_acc   = min_acc_reg;

endmodule

// File: rtl/time_scheduler.sv
// Emulation-time scheduler: HALT/SCAN/COMMIT control around time_min_scan.
// TIME_SCHEDULER_LIMIT_EN enables the time_limit stop with sticky limit_hit.
module time_scheduler
  import time_package::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk_sys,
  input  logic              rst,
  time_scheduler_if.slave   bus
);

  sched_state_t    state_reg;
  sched_state_t    state_next;
  logic            start;
  logic            done;
  logic            below;
  logic            any_valid;
  TIME_FORMAT      min_acc;
  TIME_FORMAT      req_arr [NREQ];
  logic [NREQ-1:0] eq_vec;
  logic            limit_trip;
  logic            limit_block;

  TIME_FORMAT      time_next_reg;
  logic [NREQ-1:0] time_eq_reg;
  logic            emu_tick_reg;
  logic            idle_reg;
  logic            err_reg;
  logic [31:0]     epoch_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_arr[gi] = bus.time_req[gi];
      // all requesters tied at the minimum fire together
      assign eq_vec[gi]  = bus.req_valid[gi] && (bus.time_req[gi] == min_acc);
    end
  endgenerate

  time_min_scan #(.NREQ(NREQ)) u_scan (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .start     (start),
    .time_req  (req_arr),
    .req_valid (bus.req_valid),
    .time_next (time_next_reg),
    .done      (done),
    .below     (below),
    .any_valid (any_valid),
    .min_acc   (min_acc)
  );

`ifdef TIME_SCHEDULER_LIMIT_EN
  logic limit_hit_reg;

  assign limit_trip  = any_valid && (min_acc > bus.time_limit);
  assign limit_block = limit_hit_reg;
  assign bus.limit_hit = limit_hit_reg;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      limit_hit_reg <= 1'b0;
    end else if ((state_reg == COMMIT) && limit_trip) begin
      limit_hit_reg <= 1'b1;
    end
  end
`else
  assign limit_trip  = 1'b0;
  assign limit_block = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_reg <= HALT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      HALT: begin
        if ((bus.run || bus.step) && !limit_block) begin
          state_next = SCAN;
          start      = 1'b1;
        end
      end
      SCAN: begin
        if (done) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (limit_trip) begin
          state_next = HALT;
        end else if (bus.run) begin
          state_next = SCAN;
          start      = 1'b1;
        end else begin
          state_next = HALT;
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      time_next_reg   <= '0;
      time_eq_reg     <= '0;
      emu_tick_reg    <= 1'b0;
      idle_reg        <= 1'b0;
      err_reg         <= 1'b0;
      epoch_count_reg <= '0;
    end else begin
      emu_tick_reg <= 1'b0;
      if ((state_reg == SCAN) && below) begin
        err_reg <= 1'b1;
      end
      if (state_reg == COMMIT) begin
        if (!any_valid) begin
          idle_reg <= 1'b1;
        end else if (!limit_trip) begin
          time_next_reg   <= min_acc;
          time_eq_reg     <= eq_vec;
          emu_tick_reg    <= 1'b1;
          epoch_count_reg <= epoch_count_reg + 32'd1;
          idle_reg        <= 1'b0;
        end
      end
    end
  end

  assign bus.time_next   = time_next_reg;
  assign bus.time_eq     = time_eq_reg;
  assign bus.emu_tick    = emu_tick_reg;
  assign bus.idle        = idle_reg;
  assign bus.err         = err_reg;
  assign bus.epoch_count = epoch_count_reg;

endmodule

// File: tb/tb_time_scheduler.sv
// Randomized self-checking bench for time_scheduler against an epoch-level reference model.
module tb_time_scheduler;
  import time_package::*;

  localparam int NREQ = 4;

  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  always #5 clk_sys = ~clk_sys;

  time_scheduler_if #(.NREQ(NREQ)) bus ();

  time_scheduler #(.NREQ(NREQ)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  TIME_FORMAT      req_v [NREQ];
  logic [NREQ-1:0] valid_v;
  TIME_FORMAT      lim_v;

  TIME_FORMAT      m_time_next;
  logic [NREQ-1:0] m_eq;
  logic            m_idle;
  logic            m_err;
  logic [31:0]     m_count;
  logic            m_limit;
  logic            m_tick;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) bus.time_req[i] = req_v[i];
    bus.req_valid = valid_v;
`ifdef TIME_SCHEDULER_LIMIT_EN
    bus.time_limit = lim_v;
`endif
  endtask

  task automatic model_reset();
    m_time_next = '0;
    m_eq        = '0;
    m_idle      = 1'b0;
    m_err       = 1'b0;
    m_count     = '0;
    m_limit     = 1'b0;
    m_tick      = 1'b0;
  endtask

  // Whole-epoch reference: minimum of valid requests, then everyone equal to it.
  task automatic model_epoch();
    TIME_FORMAT mn;
    bit any;
    mn  = TIME_MAX;
    any = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (valid_v[i]) begin
        any = 1;
        if (req_v[i] < m_time_next) m_err = 1'b1;
        if (req_v[i] < mn) mn = req_v[i];
      end
    end
    m_tick = 1'b0;
    if (!any) begin
      m_idle = 1'b1;
`ifdef TIME_SCHEDULER_LIMIT_EN
    end else if (mn > lim_v) begin
      m_limit = 1'b1;
`endif
    end else begin
      m_time_next = mn;
      for (int i = 0; i < NREQ; i++) m_eq[i] = valid_v[i] && (req_v[i] == mn);
      m_tick  = 1'b1;
      m_count = m_count + 32'd1;
      m_idle  = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".tick"},  bus.emu_tick,    m_tick);
    check({tag, ".next"},  bus.time_next,   m_time_next);
    check({tag, ".eq"},    bus.time_eq,     m_eq);
    check({tag, ".idle"},  bus.idle,        m_idle);
    check({tag, ".err"},   bus.err,         m_err);
    check({tag, ".count"}, bus.epoch_count, m_count);
`ifdef TIME_SCHEDULER_LIMIT_EN
    check({tag, ".limit"}, bus.limit_hit,   m_limit);
`endif
    $display("epoch %s next=%0d eq=%b tick=%0d idle=%0d err=%0d count=%0d",
             tag, bus.time_next, bus.time_eq, bus.emu_tick, bus.idle, bus.err, bus.epoch_count);
  endtask

  // Walk to the commit: 'zeros' quiet cycles, then one commit cycle.
  task automatic epoch(input string tag, input int zeros, input bit clear_run, input int drop_at);
    for (int c = 0; c < zeros; c++) begin
      @(negedge clk_sys);
      if (c == 0) begin
        bus.step = 1'b0;
        if (clear_run) bus.run = 1'b0;
      end
      if (c == drop_at) bus.run = 1'b0;
      if (bus.emu_tick !== 1'b0) begin
        errors++;
        $display("FAIL %s.early_tick got=%0d exp=0 cycle=%0d", tag, bus.emu_tick, c);
      end
    end
    checks++;
    model_epoch();
    @(negedge clk_sys);
    check_outputs(tag);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int ticks;
    ticks = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_sys);
      if (bus.emu_tick === 1'b1) ticks++;
    end
    check({tag, ".quiet"}, ticks, 0);
  endtask

  task automatic step_epoch(input string tag);
    @(negedge clk_sys);
    drive();
    bus.step = 1'b1;
    epoch(tag, NREQ + 1, 1'b0, -1);
  endtask

  initial begin
    TIME_FORMAT prev;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    for (int i = 0; i < NREQ; i++) req_v[i] = '0;
    valid_v = '0;
    lim_v   = TIME_MAX;
    drive();
    model_reset();

    repeat (3) @(negedge clk_sys);
    check_outputs("reset");
    rst = 1'b0;

    // Directed: ties at 25 flagged together, one run pulse gives one epoch
    req_v[0] = 40; req_v[1] = 25; req_v[2] = 90; req_v[3] = 25;
    valid_v  = 4'b1111;
    @(negedge clk_sys);
    drive();
    bus.run = 1'b1;
    epoch("pulse", NREQ + 1, 1'b1, -1);
    check("pulse.eq_lit", bus.time_eq, 4'b1010);
    expect_quiet("pulse_halt", 2 * (NREQ + 1));

    // Request below committed time: err sticky, still used as minimum
    req_v[0] = 10; req_v[1] = 50; req_v[2] = 60; req_v[3] = 70;
    step_epoch("below");
    check("below.next_lit", bus.time_next, 10);

    // No valid requesters: idle, nothing committed
    valid_v = '0;
    step_epoch("idle");
    expect_quiet("idle_halt", NREQ + 1);

    // Reset in the third scan cycle aborts the epoch
    valid_v = 4'b1111;
    req_v[0] = 100; req_v[1] = 200; req_v[2] = 300; req_v[3] = 400;
    @(negedge clk_sys);
    drive();
    bus.step = 1'b1;
    @(negedge clk_sys);
    bus.step = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b1;
    model_reset();
    @(negedge clk_sys);
    check_outputs("midrst");
    rst = 1'b0;
    expect_quiet("midrst_quiet", NREQ + 2);
    step_epoch("after_rst");

    // Free-running: each matched requester advances by 10
    for (int i = 0; i < NREQ; i++) req_v[i] = m_time_next + TIME_FORMAT'($urandom_range(0, 40));
    @(negedge clk_sys);
    drive();
    bus.run = 1'b1;
    epoch("run0", NREQ + 1, 1'b0, -1);
    for (int k = 1; k <= 8; k++) begin
      prev = m_time_next;
      for (int i = 0; i < NREQ; i++) if (m_eq[i]) req_v[i] = req_v[i] + 10;
      drive();
      epoch($sformatf("run%0d", k), NREQ, 1'b0, (k == 8) ? 2 : -1);
      check($sformatf("run%0d.mono", k), (bus.time_next >= prev) ? 1 : 0, 1);
    end
    expect_quiet("run_drop", 2 * (NREQ + 1));

    // Random single steps with small values to provoke ties and errors
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < NREQ; i++) req_v[i] = TIME_FORMAT'($urandom_range(0, 60));
      valid_v = NREQ'($urandom);
      step_epoch($sformatf("rnd%0d", k));
    end

`ifdef TIME_SCHEDULER_LIMIT_EN
    rst = 1'b1;
    model_reset();
    @(negedge clk_sys);
    rst = 1'b0;
    lim_v = 30;
    valid_v = 4'b1111;
    req_v[0] = 31; req_v[1] = 45; req_v[2] = 31; req_v[3] = 60;
    @(negedge clk_sys);
    drive();
    bus.run = 1'b1;
    epoch("limit", NREQ + 1, 1'b0, -1);
    expect_quiet("limit_halt", 3 * (NREQ + 1));
    check("limit.count_held", bus.epoch_count, 0);
    bus.run = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
